// File: rtl/unstripe_pkg.sv
// Shared types and constants for the byte un-striper.
package unstripe_pkg;

    // Lock state: hunting for commas, or distributing slots over lanes
    typedef enum logic {
        SEARCH = 1'b0,
        SYNCED = 1'b1
    } state_t;

    // Default idle/sync symbol
    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/comma_sync_detect.sv
// Counts consecutive idle comma symbols while searching and flags the
// sample edge that sees the SYNC_COUNT-th one (lock_c, combinational).
module comma_sync_detect
    import unstripe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
    parameter int unsigned      SYNC_COUNT = 4
) (
    input  logic             clk_f,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             search,
    output logic             lock_c
);

    localparam int unsigned CW = $clog2(SYNC_COUNT + 1);

    logic [CW-1:0] comma_cnt;
    logic          is_comma_c;

    // A comma is an idle slot carrying the sync symbol
    assign is_comma_c = !in_valid && (in_data == COMMA);

    // Lock when this comma completes the required run
    assign lock_c = search && is_comma_c && (comma_cnt == CW'(SYNC_COUNT - 1));

    // Saturating run counter; held at zero outside SEARCH so every new
    // search starts fresh
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            comma_cnt <= '0;
        end else if (!search || !is_comma_c) begin
            comma_cnt <= '0;
        end else if (comma_cnt != CW'(SYNC_COUNT)) begin
            comma_cnt <= comma_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/byte_unstriper_n.sv
// Byte un-striper: locks on a run of idle commas, then deals consecutive
// byte slots round-robin over LANES lanes and presents each completed lane
// word with per-lane valid flags and a one-cycle strobe.
// Optional feature: define UNSTRIPE_LOS_EN to drop lock after LOS_LIMIT
// consecutive non-comma idle slots.
module byte_unstriper_n
    import unstripe_pkg::*;
#(
    parameter int unsigned      LANES      = 4,
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      LOS_LIMIT  = 8
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    output logic                   out_strobe,
    output logic                   active
);

    localparam int unsigned PW = $clog2(LANES);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    lane_ptr;
    logic [PW-1:0]    lane_ptr_nxt;
    logic [WIDTH-1:0] slot_data [LANES];
    logic [LANES-1:0] slot_vld;
    logic             word_done;
    logic             lock_c;
    logic             los_hit_c;
    logic             last_slot_c;
    logic             synced_c;

    assign synced_c    = (state == SYNCED);
    assign last_slot_c = (lane_ptr == PW'(LANES - 1));

    // Comma run counter and lock pulse
    comma_sync_detect #(
        .WIDTH      (WIDTH),
        .COMMA      (COMMA),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_sync (
        .clk_f    (clk_f),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .search   (!synced_c),
        .lock_c   (lock_c)
    );

`ifdef UNSTRIPE_LOS_EN
    localparam int unsigned LW = $clog2(LOS_LIMIT + 1);

    logic [LW-1:0] los_cnt;
    logic          bad_idle_c;

    assign bad_idle_c = !in_valid && (in_data != COMMA);
    assign los_hit_c  = synced_c && bad_idle_c && (los_cnt == LW'(LOS_LIMIT - 1));

    // Run length of consecutive bad idle slots while locked
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            los_cnt <= '0;
        end else if (!synced_c || !bad_idle_c || los_hit_c) begin
            los_cnt <= '0;
        end else begin
            los_cnt <= los_cnt + LW'(1);
        end
    end
`else
    // Lock is only ever left through reset
    assign los_hit_c = (LOS_LIMIT == 0) ? 1'b0 : 1'b0;
`endif

    // Next state and lane pointer
    always_comb begin
        state_nxt    = state;
        lane_ptr_nxt = lane_ptr;
        case (state)
            SEARCH: begin
                if (lock_c) begin
                    state_nxt    = SYNCED;
                    lane_ptr_nxt = '0;
                end
            end
            SYNCED: begin
                if (los_hit_c) begin
                    state_nxt    = SEARCH;
                    lane_ptr_nxt = '0;
                end else if (last_slot_c) begin
                    lane_ptr_nxt = '0;
                end else begin
                    lane_ptr_nxt = lane_ptr + PW'(1);
                end
            end
            default: begin
                state_nxt    = SEARCH;
                lane_ptr_nxt = '0;
            end
        endcase
    end

    // State, lane pointer, lock flag and word-complete marker
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            state     <= SEARCH;
            lane_ptr  <= '0;
            active    <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            lane_ptr  <= lane_ptr_nxt;
            active    <= (state_nxt == SYNCED);
            word_done <= synced_c && last_slot_c && !los_hit_c;
        end
    end

    // Slot capture into the lane buffer while locked
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            for (int k = 0; k < int'(LANES); k++) begin
                slot_data[k] <= '0;
            end
            slot_vld <= '0;
        end else if (synced_c) begin
            slot_data[lane_ptr] <= in_valid ? in_data : '0;
            slot_vld[lane_ptr]  <= in_valid;
        end
    end

    // Output word register, loaded one edge after the last slot is captured
    always_ff @(posedge clk_f) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= '0;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= word_done;
            if (word_done) begin
                for (int k = 0; k < int'(LANES); k++) begin
                    out_data[k*WIDTH +: WIDTH] <= slot_data[k];
                end
                out_valid <= slot_vld;
            end
        end
    end

endmodule

// File: tb/tb_byte_unstriper_n.sv
// Directed bench for byte_unstriper_n: default 4x8 instance plus a 3x16
// instance for the non-power-of-two lane count.
module tb_byte_unstriper_n;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        out_strobe;
    logic        active;

    logic [15:0] in_data3;
    logic        in_valid3;
    logic [47:0] out_data3;
    logic [2:0]  out_valid3;
    logic        out_strobe3;
    logic        active3;

    int total = 0;
    int bad   = 0;

    byte_unstriper_n dut (
        .clk_f      (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_strobe (out_strobe),
        .active     (active)
    );

    byte_unstriper_n #(
        .LANES (3),
        .WIDTH (16),
        .COMMA (16'hBCBC)
    ) dut3 (
        .clk_f      (clk),
        .reset      (reset),
        .in_data    (in_data3),
        .in_valid   (in_valid3),
        .out_data   (out_data3),
        .out_valid  (out_valid3),
        .out_strobe (out_strobe3),
        .active     (active3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic tick3(input logic [15:0] d, input logic v);
        in_data3  = d;
        in_valid3 = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_data3  = 16'h0000;
        in_valid3 = 1'b0;

        // 1: reset, then partial comma run broken by data, then a full run
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        check("rst_data",   64'(out_data),   64'h0);
        check("rst_valid",  64'(out_valid),  64'h0);
        check("rst_strobe", 64'(out_strobe), 64'h0);
        check("rst_active", 64'(active),     64'h0);
        check("rst3_data",  64'(out_data3),  64'h0);
        check("rst3_active", 64'(active3),   64'h0);
        reset = 1'b1;
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'h11, 1'b1);
        check("t1_nolock_active", 64'(active),     64'h0);
        check("t1_nolock_strobe", 64'(out_strobe), 64'h0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        check("t1_three_active", 64'(active), 64'h0);
        tick(8'hBC, 1'b0);
        check("t1_lock_active", 64'(active), 64'h1);

        // 2: four valid slots
        tick(8'hFF, 1'b1);
        tick(8'hEE, 1'b1);
        tick(8'hDD, 1'b1);
        tick(8'hCC, 1'b1);
        check("t2_strobe_early", 64'(out_strobe), 64'h0);
        // 3: mixed idle/valid word, first slot presented here
        tick(8'h00, 1'b0);
        check("t2_strobe", 64'(out_strobe), 64'h1);
        check("t2_data",   64'(out_data),   64'hCCDDEEFF);
        check("t2_valid",  64'(out_valid),  64'hF);
        tick(8'hBC, 1'b0);
        check("t3_strobe_pulse", 64'(out_strobe), 64'h0);
        check("t3_hold_data",    64'(out_data),   64'hCCDDEEFF);
        tick(8'h77, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h55, 1'b1);
        check("t3_strobe", 64'(out_strobe), 64'h1);
        check("t3_data",   64'(out_data),   64'h00770000);
        check("t3_valid",  64'(out_valid),  64'h4);
        tick(8'h66, 1'b1);
        check("t3_hold_strobe", 64'(out_strobe), 64'h0);
        check("t3_hold_valid",  64'(out_valid),  64'h4);

        // 4: reset with two slots of a word pending
        reset = 1'b0;
        tick(8'hAA, 1'b1);
        check("t4_data",   64'(out_data),   64'h0);
        check("t4_valid",  64'(out_valid),  64'h0);
        check("t4_strobe", 64'(out_strobe), 64'h0);
        check("t4_active", 64'(active),     64'h0);
        reset = 1'b1;
        tick(8'h33, 1'b1);
        tick(8'h44, 1'b1);
        check("t4_search_active", 64'(active),     64'h0);
        check("t4_search_strobe", 64'(out_strobe), 64'h0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b1);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        tick(8'hBC, 1'b0);
        check("t4_relock_early", 64'(active), 64'h0);
        tick(8'hBC, 1'b0);
        check("t4_relock", 64'(active), 64'h1);

        // 5: two data slots followed by a long run of 00 idles
        tick(8'h01, 1'b1);
        tick(8'h02, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        check("t5_w1_strobe", 64'(out_strobe), 64'h1);
        check("t5_w1_data",   64'(out_data),   64'h00000201);
        check("t5_w1_valid",  64'(out_valid),  64'h3);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        check("t5_w2_strobe", 64'(out_strobe), 64'h1);
        check("t5_w2_valid",  64'(out_valid),  64'h0);
        tick(8'h00, 1'b0);
`ifdef UNSTRIPE_LOS_EN
        check("t5_los_active", 64'(active), 64'h0);
`else
        check("t5_los_active", 64'(active), 64'h1);
`endif
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
`ifdef UNSTRIPE_LOS_EN
        check("t5_w3_strobe", 64'(out_strobe), 64'h0);
        check("t5_w3_active", 64'(active),     64'h0);
`else
        check("t5_w3_strobe", 64'(out_strobe), 64'h1);
        check("t5_w3_active", 64'(active),     64'h1);
`endif

        // 6: three 16-bit lanes
        tick3(16'hBCBC, 1'b0);
        tick3(16'hBCBC, 1'b0);
        tick3(16'hBCBC, 1'b0);
        check("t6_early_active", 64'(active3), 64'h0);
        tick3(16'hBCBC, 1'b0);
        check("t6_lock_active", 64'(active3), 64'h1);
        tick3(16'h1111, 1'b1);
        tick3(16'h2222, 1'b1);
        tick3(16'h3333, 1'b1);
        check("t6_strobe_early", 64'(out_strobe3), 64'h0);
        tick3(16'h4444, 1'b1);
        check("t6_w1_strobe", 64'(out_strobe3), 64'h1);
        check("t6_w1_data",   64'(out_data3),   64'h333322221111);
        check("t6_w1_valid",  64'(out_valid3),  64'h7);
        tick3(16'h9999, 1'b0);
        check("t6_strobe_pulse", 64'(out_strobe3), 64'h0);
        tick3(16'h5555, 1'b1);
        tick3(16'h0000, 1'b0);
        check("t6_w2_strobe", 64'(out_strobe3), 64'h1);
        check("t6_w2_data",   64'(out_data3),   64'h555500004444);
        check("t6_w2_valid",  64'(out_valid3),  64'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
